// File: rtl/seq_frame_gen.sv
// Serial frame transmitter for a 1-0+-1 detector: marker 1, gap zeros, closing 1, cool-down zeros.
// Ports: clk, rst (async active-low), start, gap_len, [cont], x, busy, done, frame_cnt.
// Optional back-to-back repeat via SEQ_FRAME_GEN_REPEAT_EN (adds input cont).
module seq_frame_gen #(
  parameter int GAP_W    = 4,
  parameter int COOL_CYC = 2,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [GAP_W-1:0] gap_len,
`ifdef SEQ_FRAME_GEN_REPEAT_EN
  input  logic             cont,
`endif
  output logic             x,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] frame_cnt
);

  localparam int CW = (COOL_CYC < 2) ? 1 : $clog2(COOL_CYC + 1);
  localparam logic [CW-1:0] COOL_LD = CW'(COOL_CYC);

  typedef enum logic [2:0] {
    IDLE,
    HEAD,
    GAP,
    TAIL,
    COOL
  } state_t;

  state_t           state;
  logic [GAP_W-1:0] gap_q;
  logic [GAP_W-1:0] gcnt;
  logic [CW-1:0]    ccnt;
  logic             again;
  logic             last;

`ifdef SEQ_FRAME_GEN_REPEAT_EN
  assign again = cont;
`else
  assign again = 1'b0;
`endif

  // final cycle of a frame: edge that would return to IDLE
  assign last = ((state == TAIL) && (COOL_CYC == 0)) ||
                ((state == COOL) && (ccnt == CW'(1)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      gap_q     <= '0;
      gcnt      <= '0;
      ccnt      <= '0;
      x         <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      frame_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            // zero gap is promoted to one so the frame stays 1-0-1
            gap_q <= (gap_len == '0) ? GAP_W'(1) : gap_len;
            state <= HEAD;
            x     <= 1'b1;
            busy  <= 1'b1;
          end
        end
        HEAD: begin
          state <= GAP;
          x     <= 1'b0;
          gcnt  <= gap_q;
        end
        GAP: begin
          if (gcnt == GAP_W'(1)) begin
            state <= TAIL;
            x     <= 1'b1;
          end else begin
            gcnt <= gcnt - GAP_W'(1);
          end
        end
        TAIL: begin
          frame_cnt <= frame_cnt + CNT_W'(1);
          if (!last) begin
            state <= COOL;
            x     <= 1'b0;
            ccnt  <= COOL_LD;
          end
        end
        COOL: begin
          ccnt <= ccnt - CW'(1);
        end
        default: begin
          state <= IDLE;
          x     <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
      // frame end overrides the per-state updates above
      if (last) begin
        if (again) begin
          state <= HEAD;
          x     <= 1'b1;
        end else begin
          state <= IDLE;
          x     <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_frame_gen.sv
// Bench for seq_frame_gen: frame-position model checked every cycle
// plus directed literal expectations.
module tb_seq_frame_gen;

  localparam int GAP_W = 4;
  localparam int COOL  = 2;
  localparam int CNT_W = 2;

  logic             clk;
  logic             rst;
  logic             start;
  logic [GAP_W-1:0] gap_len;
  logic             x;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] frame_cnt;
`ifdef SEQ_FRAME_GEN_REPEAT_EN
  logic             cont;
`endif

  int checks = 0;
  int errors = 0;

  seq_frame_gen #(
    .GAP_W(GAP_W),
    .COOL_CYC(COOL),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .gap_len(gap_len),
`ifdef SEQ_FRAME_GEN_REPEAT_EN
    .cont(cont),
`endif
    .x(x),
    .busy(busy),
    .done(done),
    .frame_cnt(frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // model: pos = index of current cycle within its frame, -1 when idle
  int             pos = -1;
  int             glen = 1;
  bit             m_done = 0;
  bit             m_cont;
  logic [CNT_W-1:0] m_cnt = '0;

  always @(posedge clk) begin
`ifdef SEQ_FRAME_GEN_REPEAT_EN
    m_cont = cont;
`else
    m_cont = 1'b0;
`endif
    if (!rst) begin
      pos = -1;
      glen = 1;
      m_done = 0;
      m_cnt = '0;
    end else if (pos >= 0) begin
      if (pos == 1 + glen) m_cnt = m_cnt + 1'b1;
      pos++;
      if (pos == 2 + glen + COOL) begin
        if (m_cont) pos = 0;
        else begin
          pos = -1;
          m_done = 1;
        end
      end
    end else begin
      m_done = 0;
      if (start) begin
        glen = (gap_len == 0) ? 1 : int'(gap_len);
        pos = 0;
      end
    end
    #1;
    chk("model_x", int'(x), int'(pos == 0 || pos == 1 + glen));
    chk("model_busy", int'(busy), int'(pos >= 0));
    chk("model_done", int'(done), int'(m_done));
    chk("model_cnt", int'(frame_cnt), int'(m_cnt));
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  int xb[7] = '{1, 0, 0, 0, 1, 0, 0};
  int zb[5] = '{1, 0, 1, 0, 0};
  int wl[4] = '{1, 2, 3, 0};

  initial begin
    int k;
    int nd;
    rst = 1'b0;
    start = 1'b1;
    gap_len = 4'd5;
`ifdef SEQ_FRAME_GEN_REPEAT_EN
    cont = 1'b0;
`endif
    // reset held with start high
    repeat (3) begin
      cyc();
      chk("rst_x", int'(x), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_cnt", int'(frame_cnt), 0);
    end
    @(negedge clk);
    rst = 1'b1;
    start = 1'b0;
    @(negedge clk);

    // basic frame gap 3
    start = 1'b1;
    gap_len = 4'd3;
    cyc();
    start = 1'b0;
    chk("basic_x1", int'(x), xb[0]);
    chk("basic_busy1", int'(busy), 1);
    for (int c = 2; c <= 7; c++) begin
      cyc();
      chk("basic_x", int'(x), xb[c-1]);
      chk("basic_busy", int'(busy), 1);
    end
    cyc();
    chk("basic_done8", int'(done), 1);
    chk("basic_busy8", int'(busy), 0);
    chk("basic_cnt8", int'(frame_cnt), 1);
    cyc();
    chk("basic_done9", int'(done), 0);

    // busy ignore, then start in the done cycle with zero gap
    @(negedge clk);
    start = 1'b1;
    gap_len = 4'd3;
    cyc();
    start = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      if (c > 1) cyc();
      if (c == 3) begin
        start = 1'b1;
        gap_len = 4'd7;
      end else begin
        start = 1'b0;
        gap_len = 4'd3;
      end
      chk("ign_x", int'(x), xb[c-1]);
    end
    cyc();
    chk("ign_done8", int'(done), 1);
    chk("ign_cnt8", int'(frame_cnt), 2);
    start = 1'b1;
    gap_len = 4'd0;
    for (int c = 0; c < 5; c++) begin
      cyc();
      start = 1'b0;
      chk("zero_x", int'(x), zb[c]);
      chk("zero_busy", int'(busy), 1);
    end
    cyc();
    chk("zero_done", int'(done), 1);
    chk("zero_cnt", int'(frame_cnt), 3);

    // async reset during GAP
    @(negedge clk);
    start = 1'b1;
    gap_len = 4'd3;
    cyc();
    start = 1'b0;
    cyc();
    cyc();
    #2 rst = 1'b0;
    #1;
    chk("arst_x", int'(x), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_cnt", int'(frame_cnt), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    nd = 0;
    repeat (10) begin
      cyc();
      if (done) nd++;
    end
    chk("arst_nodone", nd, 0);
    chk("arst_cnt_after", int'(frame_cnt), 0);

    // counter wrap over four back-to-back frames
    @(negedge clk);
    start = 1'b1;
    gap_len = 4'd2;
    k = 0;
    for (int c = 0; c < 40; c++) begin
      cyc();
      if (done && k < 4) begin
        chk("wrap_cnt", int'(frame_cnt), wl[k]);
        k++;
        if (k == 4) start = 1'b0;
      end
    end
    start = 1'b0;
    chk("wrap_frames", k, 4);

`ifdef SEQ_FRAME_GEN_REPEAT_EN
    // three chained frames, single done pulse
    @(negedge clk);
    cont = 1'b1;
    start = 1'b1;
    gap_len = 4'd2;
    nd = 0;
    for (int c = 1; c <= 25; c++) begin
      cyc();
      start = 1'b0;
      if (c == 13) cont = 1'b0;
      if (c <= 18) chk("rep_busy", int'(busy), 1);
      if (done) nd++;
    end
    chk("rep_dones", nd, 1);
    chk("rep_cnt", int'(frame_cnt), 3);
`endif

    repeat (2) cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
